// File: rtl/video_pattern_tx_pkg.sv
// Shared definitions for the video pattern transmitter and its stream peers:
// FSM state encodings, test-pattern codes, the timing flag bundle passed from
// the timing generator to the pattern stage, and a small range helper.
package video_pattern_tx_pkg;

  // FSM state encodings, kept numerically fixed so other stream blocks agree
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

  // Test-pattern selector codes; codes above PAT_FLAT also produce a flat field
  localparam logic [2:0] PAT_HRAMP   = 3'd0;
  localparam logic [2:0] PAT_VRAMP   = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_BOX     = 3'd3;
  localparam logic [2:0] PAT_FLAT    = 3'd4;

  // Per-cycle decode of the raster counters
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
    logic frame_start;
    logic frame_last;
  } timing_flags_t;

  // Half-open unsigned range test: lo <= v < hi
  function automatic logic in_range(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_pattern_tx_if.sv
// Pixel stream bundle (vsync/hsync/valid/data). The transmitter drives it
// through the master modport; filters consume it through the slave modport.
interface video_pattern_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  vsync;
  logic                  hsync;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output vsync,
    output hsync,
    output valid,
    output data
  );

  modport slave (
    input vsync,
    input hsync,
    input valid,
    input data
  );
endinterface

// File: rtl/video_pattern_tx_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, sync and active
// region decode, active-area pixel coordinates and frame boundary flags.
// Counters advance only while run is high and are forced to zero otherwise,
// so every run starts on a clean frame start.
module video_pattern_tx_timing_gen
  import video_pattern_tx_pkg::*;
#(
  parameter logic [10:0] H_SYNC  = 11'd40,
  parameter logic [10:0] H_BACK  = 11'd220,
  parameter logic [10:0] H_DISP  = 11'd1280,
  parameter logic [10:0] H_TOTAL = 11'd1650,
  parameter logic [10:0] V_SYNC  = 11'd5,
  parameter logic [10:0] V_BACK  = 11'd20,
  parameter logic [10:0] V_DISP  = 11'd720,
  parameter logic [10:0] V_TOTAL = 11'd750
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output timing_flags_t flags_s,
  output logic [10:0]   pix_x_s,
  output logic [10:0]   pix_y_s
);

  localparam logic [10:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT_END   = H_ACT_START + H_DISP;
  localparam logic [10:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_END   = V_ACT_START + V_DISP;

  logic [10:0] h_cnt_r;
  logic [10:0] v_cnt_r;
  logic        h_last_s;
  logic        v_last_s;

  assign h_last_s = (h_cnt_r == (H_TOTAL - 11'd1));
  assign v_last_s = (v_cnt_r == (V_TOTAL - 11'd1));

  // Raster counters: h wraps every line, v steps on h wrap and wraps per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else if (!run) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else if (h_last_s) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= v_last_s ? 11'd0 : (v_cnt_r + 11'd1);
    end else begin
      h_cnt_r <= h_cnt_r + 11'd1;
      v_cnt_r <= v_cnt_r;
    end
  end

  assign flags_s.hsync       = (h_cnt_r < H_SYNC);
  assign flags_s.vsync       = (v_cnt_r < V_SYNC);
  assign flags_s.valid       = in_range(h_cnt_r, H_ACT_START, H_ACT_END) &
                               in_range(v_cnt_r, V_ACT_START, V_ACT_END);
  assign flags_s.frame_start = (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
  assign flags_s.frame_last  = h_last_s && v_last_s;

  // Coordinates are only meaningful inside the active region
  assign pix_x_s = h_cnt_r - H_ACT_START;
  assign pix_y_s = v_cnt_r - V_ACT_START;

endmodule

// File: rtl/video_pattern_tx.sv
// Video stream transmitter: run/stop FSM, per-frame pattern latch, test-image
// mux and registered stream outputs. All outputs lag the raster counters by
// exactly one clock. Stopping always completes the current frame.
module video_pattern_tx
  import video_pattern_tx_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter logic [10:0] H_SYNC     = 11'd40,
  parameter logic [10:0] H_BACK     = 11'd220,
  parameter logic [10:0] H_DISP     = 11'd1280,
  parameter logic [10:0] H_FRONT    = 11'd110,
  parameter logic [10:0] H_TOTAL    = 11'd1650,
  parameter logic [10:0] V_SYNC     = 11'd5,
  parameter logic [10:0] V_BACK     = 11'd20,
  parameter logic [10:0] V_DISP     = 11'd720,
  parameter logic [10:0] V_FRONT    = 11'd5,
  parameter logic [10:0] V_TOTAL    = 11'd750,
  parameter int          CHK_SHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] fg_level,
  video_pattern_tx_if.master    post_img,
  output logic                  frame_done,
  output logic                  busy
);

  // Centre box spans the middle half of the active area in each direction
  localparam logic [10:0] BOX_X_LO = H_DISP >> 2;
  localparam logic [10:0] BOX_X_HI = 11'(({2'b00, H_DISP} * 13'd3) >> 2);
  localparam logic [10:0] BOX_Y_LO = V_DISP >> 2;
  localparam logic [10:0] BOX_Y_HI = 11'(({2'b00, V_DISP} * 13'd3) >> 2);

  // Porch parameters only shape the totals; they are not decoded directly
  localparam logic [10:0] H_SUM = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_SUM = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_TOTAL_USED = (H_SUM == H_TOTAL) ? H_TOTAL : H_SUM;
  localparam logic [10:0] V_TOTAL_USED = (V_SUM == V_TOTAL) ? V_TOTAL : V_SUM;

  logic [1:0]            state_r;
  logic [1:0]            state_next_s;
  logic                  run_s;
  timing_flags_t         flags_s;
  logic [10:0]           pix_x_s;
  logic [10:0]           pix_y_s;
  logic [2:0]            pat_sel_r;
  logic [DATA_WIDTH-1:0] fg_level_r;
  logic [DATA_WIDTH-1:0] pix_data_s;
  logic                  in_box_s;

  logic                  vsync_r;
  logic                  hsync_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  frame_done_r;
  logic                  busy_r;

  assign run_s = (state_r != ST_IDLE);

  video_pattern_tx_timing_gen #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_DISP  (H_DISP),
    .H_TOTAL (H_TOTAL_USED),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_DISP  (V_DISP),
    .V_TOTAL (V_TOTAL_USED)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .flags_s (flags_s),
    .pix_x_s (pix_x_s),
    .pix_y_s (pix_y_s)
  );

  // Next-state logic: stop requests are deferred to the last frame cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable) begin
          state_next_s = ST_RUN;
        end else if (flags_s.frame_last) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP_PEND;
        end
      end
      ST_STOP_PEND: begin
        if (enable) begin
          state_next_s = ST_RUN;
        end else if (flags_s.frame_last) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP_PEND;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pattern controls are captured once per frame so a frame is never mixed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_sel_r  <= 3'd0;
      fg_level_r <= '0;
    end else if (run_s && flags_s.frame_start) begin
      pat_sel_r  <= pattern_sel;
      fg_level_r <= fg_level;
    end else begin
      pat_sel_r  <= pat_sel_r;
      fg_level_r <= fg_level_r;
    end
  end

  assign in_box_s = in_range(pix_x_s, BOX_X_LO, BOX_X_HI) &
                    in_range(pix_y_s, BOX_Y_LO, BOX_Y_HI);

  // Test-image mux from the latched pattern and current pixel coordinates
  always_comb begin
    pix_data_s = '0;
    case (pat_sel_r)
      PAT_HRAMP: begin
        pix_data_s = DATA_WIDTH'(pix_x_s[7:0]);
      end
      PAT_VRAMP: begin
        pix_data_s = DATA_WIDTH'(pix_y_s[7:0]);
      end
      PAT_CHECKER: begin
        if (pix_x_s[CHK_SHIFT] ^ pix_y_s[CHK_SHIFT]) begin
          pix_data_s = DATA_WIDTH'(8'hFF);
        end else begin
          pix_data_s = '0;
        end
      end
      PAT_BOX: begin
        if (in_box_s) begin
          pix_data_s = fg_level_r;
        end else begin
          pix_data_s = '0;
        end
      end
      PAT_FLAT: begin
        pix_data_s = fg_level_r;
      end
      default: begin
        pix_data_s = fg_level_r;
      end
    endcase
  end

  // Output stage: everything decodes this cycle's counters one clock later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_r      <= 1'b0;
      hsync_r      <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else if (run_s) begin
      vsync_r      <= flags_s.vsync;
      hsync_r      <= flags_s.hsync;
      valid_r      <= flags_s.valid;
      data_r       <= flags_s.valid ? pix_data_s : '0;
      frame_done_r <= flags_s.frame_last;
      busy_r       <= 1'b1;
    end else begin
      vsync_r      <= 1'b0;
      hsync_r      <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end
  end

  assign post_img.vsync = vsync_r;
  assign post_img.hsync = hsync_r;
  assign post_img.valid = valid_r;
  assign post_img.data  = data_r;
  assign frame_done     = frame_done_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_video_pattern_tx.sv
// Directed bench for video_pattern_tx on a 15x8 raster
// (H 2/3/8/2/15, V 1/2/4/1/8, CHK_SHIFT=1). Cycle k counts clocks after the
// edge that first sees enable=1; outputs at cycle k decode raster index k-1.
module tb_video_pattern_tx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] pattern_sel;
  logic [7:0] fg_level;
  logic       frame_done;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  video_pattern_tx_if #(.DATA_WIDTH(8)) img_if ();

  video_pattern_tx #(
    .DATA_WIDTH (8),
    .H_SYNC (11'd2), .H_BACK (11'd3), .H_DISP (11'd8), .H_FRONT (11'd2), .H_TOTAL (11'd15),
    .V_SYNC (11'd1), .V_BACK (11'd2), .V_DISP (11'd4), .V_FRONT (11'd1), .V_TOTAL (11'd8),
    .CHK_SHIFT (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .fg_level    (fg_level),
    .post_img    (img_if),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] sel;   // driven after this check
    logic [7:0] fg;    // driven after this check
    logic       vs, hs, vld;
    logic [7:0] data;
    logic       fd, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int c, input logic [2:0] s, input logic [7:0] f,
                              input logic vs, input logic hs, input logic vld,
                              input logic [7:0] d, input logic fd, input logic bsy);
    vec_t v;
    v.cyc = c; v.sel = s; v.fg = f; v.vs = vs; v.hs = hs; v.vld = vld;
    v.data = d; v.fd = fd; v.bsy = bsy;
    tbl.push_back(v);
  endfunction

  function automatic logic [12:0] snap();
    return {img_if.vsync, img_if.hsync, img_if.valid, img_if.data, frame_done, busy};
  endfunction

  task automatic check(input string name, input logic [12:0] want);
    logic [12:0] got;
    got = snap();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got vs/hs/vld/data/fd/busy=%b/%b/%b/%0d/%b/%b want %b/%b/%b/%0d/%b/%b",
               name, cyc, got[12], got[11], got[10], got[9:2], got[1], got[0],
               want[12], want[11], want[10], want[9:2], want[1], want[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  // enable taken at the next edge; that edge becomes cycle 0
  task automatic start_run();
    enable = 1'b1;
    cyc = -1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; pattern_sel = 3'd0; fg_level = 8'd0;

    // Frame 0: h-ramp; sel changed to checker mid-frame
    add(0,   3'd0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1,   3'd0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1);
    add(2,   3'd0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1);
    add(3,   3'd0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(15,  3'd0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(16,  3'd0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1);
    add(50,  3'd0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(51,  3'd0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(52,  3'd0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd1,   1'b0, 1'b1);
    add(58,  3'd0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd7,   1'b0, 1'b1);
    add(59,  3'd0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(60,  3'd2, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(96,  3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(103, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd7,   1'b0, 1'b1);
    add(111, 3'd2, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(119, 3'd2, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(120, 3'd2, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1);
    add(121, 3'd2, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1);
    // Frame 1: checker; box/200 requested mid-frame
    add(171, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(173, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    add(175, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(177, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    add(178, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    add(188, 3'd2, 8'd0,   1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    add(200, 3'd3, 8'd200, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(201, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    add(203, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(240, 3'd3, 8'd200, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1);
    // Frame 2: box fg=200; fg changed to 50 mid-frame
    add(294, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(307, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(308, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 1'b1);
    add(311, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 1'b1);
    add(312, 3'd3, 8'd200, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    add(325, 3'd3, 8'd50,  1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 1'b1);
    add(326, 3'd3, 8'd50,  1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 1'b1);
    add(339, 3'd3, 8'd50,  1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    // Frame 3: box fg=50; flat requested mid-frame
    add(428, 3'd4, 8'd50,  1'b0, 1'b0, 1'b1, 8'd50,  1'b0, 1'b1);
    add(433, 3'd4, 8'd50,  1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1);
    // Frame 4: flat 50; code 7 with fg=9 requested for the next frame
    add(530, 3'd4, 8'd50,  1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1);
    add(531, 3'd7, 8'd9,   1'b0, 1'b0, 1'b1, 8'd50,  1'b0, 1'b1);
    add(572, 3'd7, 8'd9,   1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", 13'd0);
    rst = 1'b0;
    step();
    step();
    check("idle_after_reset", 13'd0);

    start_run();
    foreach (tbl[i]) begin
      wait_to(tbl[i].cyc);
      check($sformatf("vec%0d_k%0d", i, tbl[i].cyc),
            {tbl[i].vs, tbl[i].hs, tbl[i].vld, tbl[i].data, tbl[i].fd, tbl[i].bsy});
      pattern_sel = tbl[i].sel;
      fg_level    = tbl[i].fg;
    end

    // Drop enable at frame cycle 40 of frame 5: frame completes, then idle
    wait_to(640);
    check("stop_k640", {3'b000, 8'd0, 1'b0, 1'b1});
    enable = 1'b0;
    wait_to(703);
    check("stop_last_pix", {3'b001, 8'd9, 1'b0, 1'b1});
    wait_to(719);
    check("stop_k719", {3'b000, 8'd0, 1'b0, 1'b1});
    wait_to(720);
    check("stop_frame_done", {3'b000, 8'd0, 1'b1, 1'b1});
    wait_to(721);
    check("stop_idle", 13'd0);
    for (int i = 0; i < 30; i++) begin
      step();
      check("stop_idle_hold", 13'd0);
    end

    // Restart from idle: first valid 51 clocks after enable
    start_run();
    check("restart_k0", 13'd0);
    wait_to(1);
    check("restart_k1", {3'b110, 8'd0, 1'b0, 1'b1});
    wait_to(50);
    check("restart_k50", {3'b000, 8'd0, 1'b0, 1'b1});
    wait_to(51);
    check("restart_k51", {3'b001, 8'd9, 1'b0, 1'b1});

    // Drop and reassert within one frame: no gap
    wait_to(160);
    check("blip_k160", {3'b000, 8'd0, 1'b0, 1'b1});
    enable = 1'b0;
    wait_to(180);
    check("blip_k180", {3'b000, 8'd0, 1'b0, 1'b1});
    enable = 1'b1;
    wait_to(240);
    check("blip_frame_done", {3'b000, 8'd0, 1'b1, 1'b1});
    wait_to(241);
    check("blip_next_frame", {3'b110, 8'd0, 1'b0, 1'b1});
    wait_to(291);
    check("blip_first_pix", {3'b001, 8'd9, 1'b0, 1'b1});
    wait_to(293);
    check("pre_rst_pix", {3'b001, 8'd9, 1'b0, 1'b1});

    // Asynchronous reset mid-active-line
    pattern_sel = 3'd0;
    fg_level    = 8'd0;
    enable      = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", 13'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_held", 13'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_no_enable", 13'd0);

    start_run();
    wait_to(1);
    check("rst_restart_k1", {3'b110, 8'd0, 1'b0, 1'b1});
    wait_to(51);
    check("rst_restart_k51", {3'b001, 8'd0, 1'b0, 1'b1});
    wait_to(58);
    check("rst_restart_k58", {3'b001, 8'd7, 1'b0, 1'b1});
    wait_to(59);
    check("rst_restart_k59", {3'b000, 8'd0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
